board_io_controller: RTL

Parametrised successor to the board LED/key register block. Sits on the CPU-domain APB bus and provides:
- N LEDs with per-board polarity and global PWM brightness;
- M keys with synchronisers, per-key debouncing, press/release event latching and a level interrupt;
- a read-only CPU frequency word.

Everything runs on the CPU clock; the top level instantiates it beside the PLL/reset logic.

---
 rtl/board_io_pkg.sv | 20 ++
 rtl/board_io_controller_key_debouncer.sv | 59 +++++
 rtl/board_io_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared constants for the board LED/key register block: register offsets,
// event field layout and the address decode helper.
package board_io_pkg;

  localparam logic [4:0] REG_LED    = 5'h00;
  localparam logic [4:0] REG_KEYS   = 5'h04;
  localparam logic [4:0] REG_FREQ   = 5'h08;
  localparam logic [4:0] REG_EVENT  = 5'h0C;
  localparam logic [4:0] REG_IRQ_EN = 5'h10;
  localparam logic [4:0] REG_BRIGHT = 5'h14;

  // Release-seen flags live in the upper half of EVENT and IRQ_EN.
  localparam int EVENT_RELEASE_SHIFT = 16;

  // Byte address to word-aligned register offset; the byte lane bits are ignored.
  function automatic logic [4:0] word_offset(input logic [4:0] addr);
    return addr & 5'b11100;
  endfunction

endpackage

// File: rtl/board_io_controller_key_debouncer.sv
// Per-key input conditioning: two-flop synchroniser, stability counter and
// single-cycle pulses on each accepted change of the debounced state.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 480_000
) (
  input  logic clk_cpu,
  input  logic nreset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             flip;

  assign differs = (sync_b != stable);
  assign flip    = differs && (cnt == CNT_LAST);

  // The edge pulses coincide with the flip so the event flags update on the
  // same edge as the debounced state.
  assign rise = flip & sync_b;
  assign fall = flip & ~sync_b;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (differs) begin
      if (flip) begin
        stable <= sync_b;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/board_io_controller.sv
// APB register block driving board LEDs (with polarity mask and global PWM
// brightness) and sampling debounced keys with latched press/release events.
module board_io_controller
  import board_io_pkg::*;
#(
  parameter int unsigned            NUM_LEDS        = 3,
  parameter int unsigned            NUM_KEYS        = 2,
  parameter logic [NUM_LEDS-1:0]    LED_INVERT      = 3'b011,
  parameter logic [NUM_KEYS-1:0]    KEY_INVERT      = 2'b11,
  parameter int                     DEBOUNCE_CYCLES = 480_000,
  parameter int unsigned            CPU_FREQ        = 85_661_538,
  parameter int unsigned            PWM_BITS        = 8
) (
  input  logic                clk_cpu,
  input  logic                nreset,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_LEDS-1:0] leds,
  output logic                irq,
  input  logic [4:0]          apb_PADDR,
  input  logic                apb_PSEL,
  input  logic                apb_PENABLE,
  input  logic                apb_PWRITE,
  input  logic [31:0]         apb_PWDATA,
  output logic                apb_PREADY,
  output logic [31:0]         apb_PRDATA
);

  localparam int PWM_MAX = (1 << PWM_BITS) - 2;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(PWM_MAX);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_fall;

  logic [NUM_LEDS-1:0] led_on;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  logic [NUM_KEYS-1:0] ev_press;
  logic [NUM_KEYS-1:0] ev_release;
  logic [NUM_KEYS-1:0] en_press;
  logic [NUM_KEYS-1:0] en_release;
  logic [NUM_KEYS-1:0] clr_press;
  logic [NUM_KEYS-1:0] clr_release;

  logic [4:0] addr;
  logic       wr_en;
  logic       wr_led;
  logic       wr_event;
  logic       wr_irq_en;
  logic       wr_bright;
  logic       unused_wdata;

  assign apb_PREADY   = 1'b1;
  assign addr         = word_offset(apb_PADDR);
  assign wr_en        = apb_PSEL & apb_PENABLE & apb_PWRITE;
  assign wr_led       = wr_en && (addr == REG_LED);
  assign wr_event     = wr_en && (addr == REG_EVENT);
  assign wr_irq_en    = wr_en && (addr == REG_IRQ_EN);
  assign wr_bright    = wr_en && (addr == REG_BRIGHT);
  assign unused_wdata = &{1'b0, apb_PWDATA};

  assign key_raw = keys ^ KEY_INVERT;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk_cpu(clk_cpu),
      .nreset (nreset),
      .raw    (key_raw[i]),
      .stable (key_state[i]),
      .rise   (key_rise[i]),
      .fall   (key_fall[i])
    );
  end

  // Plain read/write control registers; unmapped writes fall through untouched.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      led_on     <= '0;
      duty       <= '1;
      en_press   <= '0;
      en_release <= '0;
    end else begin
      if (wr_led) led_on <= apb_PWDATA[NUM_LEDS-1:0];
      if (wr_bright) duty <= apb_PWDATA[PWM_BITS-1:0];
      if (wr_irq_en) begin
        en_press   <= apb_PWDATA[NUM_KEYS-1:0];
        en_release <= apb_PWDATA[EVENT_RELEASE_SHIFT +: NUM_KEYS];
      end
    end
  end

  // Write-one-to-clear masks for the event flags.
  always_comb begin
    clr_press   = '0;
    clr_release = '0;
    if (wr_event) begin
      clr_press   = apb_PWDATA[NUM_KEYS-1:0];
      clr_release = apb_PWDATA[EVENT_RELEASE_SHIFT +: NUM_KEYS];
    end
  end

  // Latch key edges; a new edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      ev_press   <= '0;
      ev_release <= '0;
    end else begin
      ev_press   <= (ev_press & ~clr_press) | key_rise;
      ev_release <= (ev_release & ~clr_release) | key_fall;
    end
  end

  // Level interrupt follows the enabled event flags one cycle later.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      irq <= 1'b0;
    end else begin
      irq <= |((ev_press & en_press) | (ev_release & en_release));
    end
  end

  // Free-running PWM phase counter with a period of 2^PWM_BITS-1 cycles.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign pwm_on = (duty == '1) | (pwm_cnt < duty);

  // Registered LED pins with board polarity applied last.
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      leds <= LED_INVERT;
    end else begin
      leds <= (led_on & {NUM_LEDS{pwm_on}}) ^ LED_INVERT;
    end
  end

  // Combinational read mux; unmapped offsets and unused bits read as zero.
  always_comb begin
    apb_PRDATA = '0;
    case (addr)
      REG_LED:    apb_PRDATA[NUM_LEDS-1:0] = led_on;
      REG_KEYS:   apb_PRDATA[NUM_KEYS-1:0] = key_state;
      REG_FREQ:   apb_PRDATA = 32'(CPU_FREQ);
      REG_EVENT: begin
        apb_PRDATA[NUM_KEYS-1:0]                      = ev_press;
        apb_PRDATA[EVENT_RELEASE_SHIFT +: NUM_KEYS]   = ev_release;
      end
      REG_IRQ_EN: begin
        apb_PRDATA[NUM_KEYS-1:0]                      = en_press;
        apb_PRDATA[EVENT_RELEASE_SHIFT +: NUM_KEYS]   = en_release;
      end
      REG_BRIGHT: apb_PRDATA[PWM_BITS-1:0] = duty;
      default:    apb_PRDATA = '0;
    endcase
  end

endmodule
